// File: rtl/burst_scheduler.sv
// Burst scheduler for a resonant driver.
// Runs the IDLE -> ARM -> BURST -> STOP -> COOLDOWN sequence and drops to FAULT on overcurrent.
// Build option: define OCD_LATCH_EN to hold FAULT until reset.
// Without OCD_LATCH_EN, FAULT releases after a hold time with ocd low.
module burst_scheduler #(
   parameter int CLK_MHZ          = 100,
   parameter int ON_TIME_MAX_US   = 200,
   parameter int MIN_OFF_US       = 1000,
   parameter int STOP_TIMEOUT_CYC = 64,
   parameter int FAULT_HOLD_US    = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   input  logic ocd,
   input  logic fb,
   output logic drv_en,
   output logic sel_rst,
   output logic busy,
   output logic fault,
   output logic trunc
);

   localparam int ON_CYC  = CLK_MHZ * ON_TIME_MAX_US;
   localparam int OFF_CYC = CLK_MHZ * MIN_OFF_US;

   // Each counter is just wide enough for its terminal value (cycles - 1).
   localparam int ON_W   = (ON_CYC > 1) ? $clog2(ON_CYC) : 1;
   localparam int OFF_W  = (OFF_CYC > 1) ? $clog2(OFF_CYC) : 1;
   localparam int STOP_W = (STOP_TIMEOUT_CYC > 1) ? $clog2(STOP_TIMEOUT_CYC) : 1;

   localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(ON_CYC - 1);
   localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(OFF_CYC - 1);
   localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_TIMEOUT_CYC - 1);

`ifndef OCD_LATCH_EN
   localparam int HOLD_CYC = CLK_MHZ * FAULT_HOLD_US;
   localparam int HOLD_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   logic [HOLD_W-1:0] hold_cnt;
`endif

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      BURST,
      STOP,
      COOLDOWN,
      FAULT
   } state_t;

   state_t            state;
   logic [ON_W-1:0]   on_cnt;
   logic [OFF_W-1:0]  off_cnt;
   logic [STOP_W-1:0] stop_cnt;

   // trig_lo remembers that trig was low last cycle. It clears on reset, so a
   // trig already high when reset ends cannot register as a rising edge.
   logic trig_lo;
   logic fb_q;
   logic trig_rise;
   logic fb_fall;

   assign trig_rise = trig & trig_lo;
   assign fb_fall   = fb_q & ~fb;

   // Sequencer: next state, counters and registered outputs in one place.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         trig_lo  <= 1'b0;
         fb_q     <= 1'b0;
         on_cnt   <= '0;
         off_cnt  <= '0;
         stop_cnt <= '0;
`ifndef OCD_LATCH_EN
         hold_cnt <= '0;
`endif
         drv_en   <= 1'b0;
         sel_rst  <= 1'b0;
         busy     <= 1'b0;
         fault    <= 1'b0;
         trunc    <= 1'b0;
      end else begin
         trig_lo <= ~trig;
         fb_q    <= fb;
         sel_rst <= 1'b0;
         trunc   <= 1'b0;
         if (ocd && state != FAULT) begin
            // Overcurrent wins over every other transition.
            state    <= FAULT;
            drv_en   <= 1'b0;
            busy     <= 1'b1;
            fault    <= 1'b1;
`ifndef OCD_LATCH_EN
            hold_cnt <= '0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (trig_rise) begin
                     state   <= ARM;
                     sel_rst <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
               ARM: begin
                  state  <= BURST;
                  drv_en <= 1'b1;
                  on_cnt <= '0;
               end
               BURST: begin
                  if (!trig || on_cnt == ON_LAST) begin
                     state    <= STOP;
                     stop_cnt <= '0;
                     trunc    <= (on_cnt == ON_LAST);
                  end else begin
                     on_cnt <= on_cnt + 1'b1;
                  end
               end
               STOP: begin
                  if (fb_fall || stop_cnt == STOP_LAST) begin
                     state   <= COOLDOWN;
                     drv_en  <= 1'b0;
                     off_cnt <= '0;
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
               COOLDOWN: begin
                  if (off_cnt == OFF_LAST) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     off_cnt <= off_cnt + 1'b1;
                  end
               end
               FAULT: begin
`ifdef OCD_LATCH_EN
                  state <= FAULT;
`else
                  if (ocd) begin
                     hold_cnt <= '0;
                  end else if (hold_cnt == HOLD_LAST) begin
                     state   <= COOLDOWN;
                     fault   <= 1'b0;
                     off_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
`endif
               end
               default: begin
                  state  <= IDLE;
                  drv_en <= 1'b0;
                  busy   <= 1'b0;
                  fault  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_burst_scheduler.sv
// Scoreboard bench for burst_scheduler.
// Expected output vectors {drv_en, sel_rst, busy, fault, trunc} are queued as stimulus is driven.
// A monitor pops each vector one edge later and compares it against the DUT outputs.
module tb_burst_scheduler;

   logic clk = 1'b0;
   logic rst, trig, ocd, fb;
   logic drv_en, sel_rst, busy, fault, trunc;

   int n_tot = 0;
   int n_bad = 0;
   int cyc_n = 0;

   typedef struct {
      int         cyc;
      int         sc;
      int         k;
      logic [4:0] v;
   } exp_t;

   exp_t sb[$];

   burst_scheduler #(
      .CLK_MHZ(10),
      .ON_TIME_MAX_US(20),
      .MIN_OFF_US(10),
      .STOP_TIMEOUT_CYC(16),
      .FAULT_HOLD_US(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .trig(trig),
      .ocd(ocd),
      .fb(fb),
      .drv_en(drv_en),
      .sel_rst(sel_rst),
      .busy(busy),
      .fault(fault),
      .trunc(trunc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Burst timeline: ARM output at ta, drive until tc, cooldown until ti, trunc at ttr.
   function automatic logic [4:0] tl(int k, int ta, int tc, int ti, int ttr);
      if (k < ta) return 5'b00000;
      if (k == ta) return 5'b01100;
      if (k < tc) return {1'b1, 1'b0, 1'b1, 1'b0, (k == ttr)};
      if (k < ti) return 5'b00100;
      return 5'b00000;
   endfunction

   // Fault timeline: ARM at 0, burst until tf, fault until tc, cooldown until ti.
   function automatic logic [4:0] ft(int k, int tf, int tc, int ti);
      if (k < 0) return 5'b00000;
      if (k == 0) return 5'b01100;
      if (k < tf) return 5'b10100;
      if (k < tc) return 5'b00110;
      if (k < ti) return 5'b00100;
      return 5'b00000;
   endfunction

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic drive(input int sc, input int k, input logic t, input logic o,
                        input logic f, input logic r, input logic [4:0] e);
      trig = t;
      ocd  = o;
      fb   = f;
      rst  = r;
      sb.push_back('{cyc: cyc_n + 1, sc: sc, k: k, v: e});
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare DUT outputs against the queued expectation for this cycle.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
         e = sb.pop_front();
         chk($sformatf("s%0d_k%0d", e.sc, e.k),
             {27'd0, drv_en, sel_rst, busy, fault, trunc}, {27'd0, e.v});
      end
   end

   initial begin
      rst  = 1'b1;
      trig = 1'b1;
      ocd  = 1'b0;
      fb   = 1'b0;
      @(posedge clk);
      #1;

      // Reset with trig held high, then trig stays high: no burst may start.
      for (int k = 0; k < 3; k++) drive(0, k, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00000);
      for (int k = 3; k < 9; k++) drive(0, k, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);

      // Normal burst, trig 50 cycles, fb toggling every 5 cycles.
      for (int k = -2; k <= 165; k++)
         drive(1, k, (k >= 0 && k < 50), 1'b0, (k >= 0) ? 1'(((k / 5) % 2)) : 1'b0,
               1'b0, tl(k, 0, 60, 160, -1));

      // trig held high: truncation, timeout stop, no rearm until trig toggles.
      for (int k = -2; k <= 525; k++)
         drive(2, k, (k >= 0 && k < 400) || k == 401, 1'b0, 1'b0, 1'b0,
               (k < 401) ? tl(k, 0, 217, 317, 201) : tl(k, 401, 419, 519, -1));

      // trig drops in the same cycle the on-time limit is reached.
      for (int k = -2; k <= 320; k++)
         drive(3, k, (k >= 0 && k <= 200), 1'b0, 1'b0, 1'b0, tl(k, 0, 217, 317, 201));

      // trig low at burst cycle 30, fb stuck low; trig edges during cooldown ignored.
      for (int k = -2; k <= 165; k++)
         drive(4, k, (k >= 0 && k < 32) || k == 60 || (k >= 140 && k <= 160),
               1'b0, 1'b0, 1'b0, tl(k, 0, 48, 148, -1));

`ifdef OCD_LATCH_EN
      // Overcurrent at burst cycle 10: fault latched until reset.
      for (int k = -2; k <= 110; k++)
         drive(5, k, (k >= 0), (k == 12 || k == 30), 1'b0, (k == 100),
               (k >= 100) ? 5'b00000 : ft(k, 12, 1 << 20, 1 << 20));
`else
      // Overcurrent at burst cycle 10, re-asserted mid-fault to restart the hold.
      for (int k = -2; k <= 185; k++)
         drive(5, k, (k >= 0 && k <= 185), (k == 12 || k == 30), 1'b0, 1'b0,
               ft(k, 12, 80, 180));
`endif

      // Reset mid-burst together with ocd; held trig after reset is not an edge.
      for (int k = -2; k <= 165; k++)
         drive(6, k, (k >= 0 && k <= 40) || k == 42, (k == 20), 1'b0, (k == 20),
               (k < 20) ? tl(k, 0, 1000, 1000, -1) :
               (k == 20) ? 5'b00000 : tl(k, 42, 60, 160, -1));

      trig = 1'b0;
      ocd  = 1'b0;
      rst  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
